// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM and a small
// show-ahead receive FIFO with sticky framing-error and overrun flags.
module uart_rx_core #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              rx_en,
    input  logic [DIV_W-1:0]                  baud_div,
    input  logic                              uart_rx,
    output logic [7:0]                        rx_data,
    output logic                              rx_valid,
    input  logic                              rx_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              rx_busy,
    output logic                              frame_err,
    output logic                              overrun,
    input  logic                              err_clr
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH+1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic             sync1_reg, rxs_reg, rxs_d_reg;
    logic [1:0]       state_reg;
    logic [DIV_W-1:0] cnt_reg, div_reg;
    logic [DIV_W-1:0] div_eff, half_div;
    logic [2:0]       bit_idx_reg;
    logic [7:0]       shift_reg;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             frame_err_reg, overrun_reg;
    logic             start_edge, stop_sample, push, bad_stop;
    logic             pop, full, drop, wr_en;

    assign div_eff     = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;
    assign half_div    = div_reg >> 1;
    assign start_edge  = rx_en && (state_reg == ST_IDLE) && rxs_d_reg && !rxs_reg;
    assign stop_sample = rx_en && (state_reg == ST_STOP) && (cnt_reg == div_reg - DIV_W'(1));
    assign push        = stop_sample && rxs_reg;
    assign bad_stop    = stop_sample && !rxs_reg;

    assign rx_valid = (count_reg != '0);
    assign full     = (count_reg == CW'(FIFO_DEPTH));
    assign pop      = rx_valid && rx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign drop     = push && full && !pop;
    assign wr_en    = push && !drop;

    assign rx_data    = rx_valid ? mem[rd_ptr_reg] : 8'h00;
    assign fifo_count = count_reg;
    assign rx_busy    = (state_reg != ST_IDLE);
    assign frame_err  = frame_err_reg;
    assign overrun    = overrun_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_reg <= 1'b1;
            rxs_reg   <= 1'b1;
            rxs_d_reg <= 1'b1;
        end else begin
            sync1_reg <= uart_rx;
            rxs_reg   <= sync1_reg;
            rxs_d_reg <= rxs_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            div_reg     <= DIV_W'(2);
            shift_reg   <= '0;
        end else if (!rx_en) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start_edge) begin
                        cnt_reg   <= '0;
                        div_reg   <= div_eff;
                        state_reg <= ST_START;
                    end
                end
                ST_START: begin
                    // Half a bit in: a line that is high again was only a glitch.
                    if (cnt_reg == half_div - DIV_W'(1)) begin
                        cnt_reg     <= '0;
                        bit_idx_reg <= '0;
                        state_reg   <= rxs_reg ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_reg <= cnt_reg + DIV_W'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_reg == div_reg - DIV_W'(1)) begin
                        cnt_reg                <= '0;
                        shift_reg[bit_idx_reg] <= rxs_reg;
                        if (bit_idx_reg == 3'd7) begin
                            state_reg <= ST_STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + DIV_W'(1);
                    end
                end
                default: begin
                    if (cnt_reg == div_reg - DIV_W'(1)) begin
                        cnt_reg   <= '0;
                        state_reg <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + DIV_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= shift_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Set events take priority over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            if (bad_stop) begin
                frame_err_reg <= 1'b1;
            end else if (err_clr) begin
                frame_err_reg <= 1'b0;
            end
            if (drop) begin
                overrun_reg <= 1'b1;
            end else if (err_clr) begin
                overrun_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: frames are driven bit by bit on uart_rx at a
// fixed clocks-per-bit and results are checked against hand-computed values.
module tb_uart_rx_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_en;
    logic [15:0] baud_div;
    logic        uart_rx;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [2:0]  fifo_count;
    logic        rx_busy;
    logic        frame_err;
    logic        overrun;
    logic        err_clr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_rx_core #(.FIFO_DEPTH(4), .DIV_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_en      (rx_en),
        .baud_div   (baud_div),
        .uart_rx    (uart_rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .fifo_count (fifo_count),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .err_clr    (err_clr)
    );

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int d);
        $display("tx byte=%02h stop=%0b clk_per_bit=%0d", b, stop_bit, d);
        @(posedge clk); #1 uart_rx = 1'b0;
        repeat (d) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 uart_rx = b[i];
            repeat (d) @(posedge clk);
        end
        #1 uart_rx = stop_bit;
        repeat (d) @(posedge clk);
        #1 uart_rx = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic pop_one();
        @(negedge clk); rx_ready = 1'b1;
        @(posedge clk); #1 rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", rx_valid); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%02h exp=00", rx_data); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", rx_busy); end
        total++; if ({frame_err, overrun} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%02b exp=00", {frame_err, overrun}); end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        $display("reset done");
    endtask

    task automatic test_basic();
        send_frame(8'h55, 1'b1, 8);
        @(negedge clk);
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0b exp=1", rx_valid); end
        total++; if (rx_data !== 8'h55) begin bad++; $display("FAIL basic_data0 got=%02h exp=55", rx_data); end
        total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL basic_count1 got=%0d exp=1", fifo_count); end
        send_frame(8'hA5, 1'b1, 8);
        @(negedge clk);
        total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL basic_count2 got=%0d exp=2", fifo_count); end
        total++; if (rx_data !== 8'h55) begin bad++; $display("FAIL basic_head got=%02h exp=55", rx_data); end
        pop_one();
        @(negedge clk);
        total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL basic_data1 got=%02h exp=a5", rx_data); end
        total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL basic_count3 got=%0d exp=1", fifo_count); end
        pop_one();
        @(negedge clk);
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL basic_count4 got=%0d exp=0", fifo_count); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL basic_empty got=%0b exp=0", rx_valid); end
        total++; if ({frame_err, overrun} !== 2'b00) begin bad++; $display("FAIL basic_flags got=%02b exp=00", {frame_err, overrun}); end
    endtask

    task automatic test_glitch();
        $display("glitch 2 clk low");
        @(posedge clk); #1 uart_rx = 1'b0;
        repeat (2) @(posedge clk);
        #1 uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL glitch_busy got=%0b exp=1", rx_busy); end
        repeat (8) @(posedge clk);
        @(negedge clk);
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL glitch_idle got=%0b exp=0", rx_busy); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL glitch_count got=%0d exp=0", fifo_count); end
        total++; if ({frame_err, overrun} !== 2'b00) begin bad++; $display("FAIL glitch_flags got=%02b exp=00", {frame_err, overrun}); end
    endtask

    task automatic test_frame_err();
        send_frame(8'h3C, 1'b0, 8);
        @(negedge clk);
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL ferr_set got=%0b exp=1", frame_err); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL ferr_count got=%0d exp=0", fifo_count); end
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        @(negedge clk);
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL ferr_clr got=%0b exp=0", frame_err); end
        send_frame(8'hFF, 1'b1, 8);
        @(negedge clk);
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL ferr_next_valid got=%0b exp=1", rx_valid); end
        total++; if (rx_data !== 8'hFF) begin bad++; $display("FAIL ferr_next_data got=%02h exp=ff", rx_data); end
        pop_one();
    endtask

    task automatic test_overrun();
        logic [7:0] exp_b;
        for (int i = 1; i <= 5; i++) begin
            exp_b = 8'(i);
            send_frame(exp_b, 1'b1, 8);
        end
        @(negedge clk);
        total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL ovr_count got=%0d exp=4", fifo_count); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%0b exp=1", overrun); end
        for (int i = 1; i <= 4; i++) begin
            exp_b = 8'(i);
            @(negedge clk);
            total++; if (rx_data !== exp_b) begin bad++; $display("FAIL ovr_pop got=%02h exp=%02h", rx_data, exp_b); end
            pop_one();
        end
        @(negedge clk);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL ovr_empty got=%0b exp=0", rx_valid); end
        send_frame(8'h77, 1'b1, 8);
        @(negedge clk);
        total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL ovr_refill got=%0d exp=1", fifo_count); end
    endtask

    task automatic test_reset_mid_frame();
        fork
            send_frame(8'hFF, 1'b1, 8);
            begin
                repeat (30) @(posedge clk);
                #1 rst_n = 1'b0;
                @(posedge clk);
                @(negedge clk);
                total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%0b exp=0", rx_valid); end
                total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rmid_data got=%02h exp=00", rx_data); end
                total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL rmid_count got=%0d exp=0", fifo_count); end
                total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%0b exp=0", rx_busy); end
                total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rmid_ovr got=%0b exp=0", overrun); end
                @(posedge clk); #1 rst_n = 1'b1;
            end
        join
        @(negedge clk);
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL rmid_nopush got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_back_to_back();
        send_frame(8'h11, 1'b1, 8);
        send_frame(8'h22, 1'b1, 8);
        send_frame(8'h33, 1'b1, 8);
        send_frame(8'h44, 1'b1, 8);
        @(negedge clk);
        total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL b2b_fill got=%0d exp=4", fifo_count); end
        fork
            send_frame(8'h00, 1'b1, 8);
            begin
                // Stop sample of this frame lands on the 80th edge after the frame starts.
                repeat (79) @(posedge clk);
                #1 rx_ready = 1'b1;
                @(posedge clk);
                #1 rx_ready = 1'b0;
            end
        join
        @(negedge clk);
        total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL b2b_count got=%0d exp=4", fifo_count); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_ovr got=%0b exp=0", overrun); end
        total++; if (rx_data !== 8'h22) begin bad++; $display("FAIL b2b_pop0 got=%02h exp=22", rx_data); end
        pop_one();
        @(negedge clk);
        total++; if (rx_data !== 8'h33) begin bad++; $display("FAIL b2b_pop1 got=%02h exp=33", rx_data); end
        pop_one();
        @(negedge clk);
        total++; if (rx_data !== 8'h44) begin bad++; $display("FAIL b2b_pop2 got=%02h exp=44", rx_data); end
        pop_one();
        @(negedge clk);
        total++; if ({rx_valid, rx_data} !== 9'h100) begin bad++; $display("FAIL b2b_pop3 got=%0b/%02h exp=1/00", rx_valid, rx_data); end
        pop_one();
        @(negedge clk);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%0b exp=0", rx_valid); end
    endtask

    task automatic test_div_clamp();
        baud_div = 16'd1;
        send_frame(8'hB6, 1'b1, 2);
        @(negedge clk);
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL clamp_valid got=%0b exp=1", rx_valid); end
        total++; if (rx_data !== 8'hB6) begin bad++; $display("FAIL clamp_data got=%02h exp=b6", rx_data); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL clamp_ferr got=%0b exp=0", frame_err); end
        pop_one();
        baud_div = 16'd8;
    endtask

    task automatic test_abort();
        fork
            send_frame(8'hC3, 1'b1, 8);
            begin
                repeat (40) @(posedge clk);
                #1;
                total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL abort_busy_before got=%0b exp=1", rx_busy); end
                rx_en = 1'b0;
                @(posedge clk); #1;
                total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL abort_busy_after got=%0b exp=0", rx_busy); end
            end
        join
        rx_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL abort_count got=%0d exp=0", fifo_count); end
        total++; if ({frame_err, overrun} !== 2'b00) begin bad++; $display("FAIL abort_flags got=%02b exp=00", {frame_err, overrun}); end
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_en    = 1'b1;
        baud_div = 16'd8;
        uart_rx  = 1'b1;
        rx_ready = 1'b0;
        err_clr  = 1'b0;
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_reset_mid_frame();
        test_back_to_back();
        test_div_clamp();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
